// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter. Sends one command byte per accepted start:
// clock inhibit, request-to-send, then 11 device-clocked bits with odd parity and an ACK check.
// Ports: clk/rst; tx_byte_i/tx_start_i in; raw PS2_CLK_i/PS2_DAT_i in; open-drain pull-low
// enables PS2_CLK_oe_o/PS2_DAT_oe_o; status tx_busy_o, tx_done_o (pulse), tx_err_o (pulse).
module ps2_host_tx #(
    parameter int CLK_INHIBIT_CYCLES = 5000,
    parameter int DATA_SETUP_CYCLES  = 50,
    parameter int TIMEOUT_CYCLES     = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_byte_i,
    input  logic       tx_start_i,
    input  logic       PS2_CLK_i,
    input  logic       PS2_DAT_i,
    output logic       PS2_CLK_oe_o,
    output logic       PS2_DAT_oe_o,
    output logic       tx_busy_o,
    output logic       tx_done_o,
    output logic       tx_err_o
);

    // One shared counter times inhibit, data setup and the inter-edge timeout.
    localparam int CMAX_A = (CLK_INHIBIT_CYCLES > DATA_SETUP_CYCLES) ? CLK_INHIBIT_CYCLES : DATA_SETUP_CYCLES;
    localparam int CMAX   = (CMAX_A > TIMEOUT_CYCLES) ? CMAX_A : TIMEOUT_CYCLES;
    localparam int CW     = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        RELEASE,
        SEND,
        ACK,
        WAIT_IDLE
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [3:0]      edge_cnt;
    logic [9:0]      frame;
    logic            dat_drv;
    logic            done_q, err_q;

    logic            clk_meta, sync_clk, clk_prev;
    logic            dat_meta, sync_dat;
    logic            fall;

    logic            accept, cnt_clr, shift, done_nxt, err_nxt, tmo;

    // Synchronizers reset to the idle-high line level so reset never fakes a falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_meta <= 1'b1;
            sync_clk <= 1'b1;
            clk_prev <= 1'b1;
            dat_meta <= 1'b1;
            sync_dat <= 1'b1;
        end else begin
            clk_meta <= PS2_CLK_i;
            sync_clk <= clk_meta;
            clk_prev <= sync_clk;
            dat_meta <= PS2_DAT_i;
            sync_dat <= dat_meta;
        end
    end

    assign fall = clk_prev & ~sync_clk;
    assign tmo  = (cnt == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        cnt_clr   = 1'b0;
        shift     = 1'b0;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (tx_start_i) begin
                    accept    = 1'b1;
                    cnt_clr   = 1'b1;
                    state_nxt = INHIBIT;
                end
            end
            INHIBIT: begin
                if (cnt == CW'(CLK_INHIBIT_CYCLES - 1)) begin
                    cnt_clr   = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (cnt == CW'(DATA_SETUP_CYCLES - 1)) begin
                    cnt_clr   = 1'b1;
                    state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                if (fall) begin
                    shift     = 1'b1;
                    cnt_clr   = 1'b1;
                    state_nxt = SEND;
                end else if (tmo) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            SEND: begin
                // Falls 2..10 put out data bits 1..7, parity and finally the stop bit.
                if (fall) begin
                    shift   = 1'b1;
                    cnt_clr = 1'b1;
                    if (edge_cnt == 4'd9) state_nxt = ACK;
                end else if (tmo) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            ACK: begin
                if (fall) begin
                    cnt_clr = 1'b1;
                    if (sync_dat) begin
                        err_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = WAIT_IDLE;
                    end
                end else if (tmo) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WAIT_IDLE: begin
                if (sync_clk && sync_dat) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else if (fall) begin
                    cnt_clr = 1'b1;
                end else if (tmo) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            edge_cnt <= '0;
            frame    <= '1;
            dat_drv  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= done_nxt;
            err_q  <= err_nxt;

            if (state == IDLE || cnt_clr) cnt <= '0;
            else                          cnt <= cnt + 1'b1;

            if (accept) begin
                frame    <= {1'b1, ~^tx_byte_i, tx_byte_i};
                edge_cnt <= '0;
            end else if (shift) begin
                // Open drain: a 0 bit is driven by pulling low, a 1 bit by releasing.
                dat_drv  <= ~frame[0];
                frame    <= {1'b1, frame[9:1]};
                edge_cnt <= edge_cnt + 1'b1;
            end
        end
    end

    // Enables decode straight from state so an async reset releases the bus at once.
    assign PS2_CLK_oe_o = (state == INHIBIT) || (state == REQ);
    assign PS2_DAT_oe_o = (state == REQ) || (state == RELEASE) || ((state == SEND) && dat_drv);
    assign tx_busy_o    = (state != IDLE);
    assign tx_done_o    = done_q;
    assign tx_err_o     = err_q;

endmodule
